// File: rtl/buttfly_sdf_stage_if.sv
// Bundle of the signals between a radix-2 SDF stage, its upstream source, its
// downstream sink and the combinational butterfly it feeds.
interface buttfly_sdf_stage_if #(
  parameter int W     = 4,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(2 * DEPTH);

  // Handshakes: a word moves on a rising edge where valid & ready are both high.
  // A held valid keeps its data stable until it moves. in_ready never looks at in_valid.
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_data;
  logic            flush;
  logic [2*W-1:0]  bf_pi;
  logic [2*W-1:0]  bf_po;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            out_kind;
  logic            out_last;
  logic [CW-1:0]   dbg_cnt;
  logic            dbg_primed;
  logic            dbg_flushing;

  modport slave (
    input  in_valid, in_data, flush, bf_po, out_ready,
    output in_ready, bf_pi, out_valid, out_data, out_kind, out_last,
           dbg_cnt, dbg_primed, dbg_flushing
  );

  modport master (
    output in_valid, in_data, flush, bf_po, out_ready,
    input  in_ready, bf_pi, out_valid, out_data, out_kind, out_last,
           dbg_cnt, dbg_primed, dbg_flushing
  );
endinterface

// File: rtl/buttfly_sdf_stage.sv
// Radix-2 single-path delay-feedback stage: pairs samples n and n+DEPTH for an
// external butterfly, emits sums at once and replays the differences next frame.
module buttfly_sdf_stage #(
  parameter int W     = 4,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  buttfly_sdf_stage_if.slave bus
);
  localparam int CW = $clog2(2 * DEPTH);
  localparam int IW = $clog2(DEPTH);

  localparam logic [0:0] PH_FILL = 1'b0;
  localparam logic [0:0] PH_BFLY = 1'b1;

  logic [CW-1:0] cnt;
  logic          primed;
  logic          flushing;
  logic [W-1:0]  dly_buf [DEPTH];

  logic          out_valid_q;
  logic [W-1:0]  out_data_q;
  logic          out_kind_q;
  logic          out_last_q;

  logic [0:0]    phase;
  logic [IW-1:0] idx;
  logic [W-1:0]  src;
  logic          emits;
  logic          out_free;
  logic          flush_start;
  logic          advance;
  logic          half_end;
  logic          frame_end;

  always_comb begin
    phase       = cnt[CW-1];
    idx         = cnt[IW-1:0];
    src         = flushing ? '0 : bus.in_data;
    emits       = (phase == PH_BFLY) | primed;
    out_free    = !emits | !out_valid_q | bus.out_ready;
    flush_start = bus.flush & (cnt == '0) & primed & !flushing;
    // The flush request owns the cycle it starts on, so a coincident input is not taken.
    advance     = (flushing | bus.in_valid) & !flush_start & out_free;
    half_end    = (cnt == CW'(DEPTH - 1));
    frame_end   = (cnt == CW'(2 * DEPTH - 1));
  end

  assign bus.in_ready     = !flushing & !flush_start & out_free;
  assign bus.bf_pi        = {src, dly_buf[idx]};
  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_kind     = out_kind_q;
  assign bus.out_last     = out_last_q;
  assign bus.dbg_cnt      = cnt;
  assign bus.dbg_primed   = primed;
  assign bus.dbg_flushing = flushing;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      primed      <= 1'b0;
      flushing    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_kind_q  <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      if (flush_start) begin
        flushing <= 1'b1;
      end

      if (advance) begin
        if (flushing && half_end) begin
          flushing <= 1'b0;
          primed   <= 1'b0;
          cnt      <= '0;
        end else begin
          cnt <= cnt + 1'b1;
          if (frame_end) begin
            primed <= 1'b1;
          end
        end
      end

      if (advance && emits) begin
        out_valid_q <= 1'b1;
        if (phase == PH_BFLY) begin
          out_data_q <= bus.bf_po[W-1:0];
          out_kind_q <= 1'b0;
          out_last_q <= 1'b0;
        end else begin
          out_data_q <= dly_buf[idx];
          out_kind_q <= 1'b1;
          out_last_q <= half_end;
        end
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Buffer holds first-half samples during FILL and differences during BFLY;
  // primed alone decides whether its contents are ever emitted, so no reset.
  always_ff @(posedge clk) begin
    if (advance) begin
      dly_buf[idx] <= (phase == PH_BFLY) ? bus.bf_po[2*W-1:W] : src;
    end
  end
endmodule
